// File: rtl/hamming_pkg.sv
// Shared SEC-DED Hamming helpers for protected registers.
//   hamming_p(width)              : number of Hamming check bits P for a data width
//   hamming_encode(data, width)   : P Hamming bits plus overall parity in bit P
//   hamming_decode(data, par, w)  : syndrome, single/double flags and corrected data
// Data and parity travel zero-extended to MAX_W / PW bits so one set of functions
// serves every width from 4 to 64.
package hamming_pkg;

  localparam int MAX_W = 64;
  localparam int MAX_P = 7;
  localparam int PW    = MAX_P + 1;
  localparam int MAX_N = MAX_W + MAX_P;

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } hc_state_e;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic [MAX_P-1:0] syndrome;
    logic             single_err;
    logic             double_err;
  } hc_dec_t;

  // Smallest p with 2^p >= width + p + 1 (scanned downwards so the last hit wins).
  function automatic int hamming_p(input int width);
    int p;
    p = MAX_P;
    for (int i = MAX_P; i >= 0; i--) begin
      if ((1 << i) >= width + i + 1) p = i;
    end
    return p;
  endfunction

  // Codeword positions 1..width+p; powers of two hold check bits, the rest
  // hold data LSB first. Each data bit toggles the check bits named by the
  // binary digits of its position.
  function automatic logic [PW-1:0] hamming_encode(input logic [MAX_W-1:0] data,
                                                   input int width);
    logic [PW-1:0] par;
    logic          ovr;
    int            p;
    int            di;
    p   = hamming_p(width);
    par = '0;
    ovr = 1'b0;
    di  = 0;
    for (int pos = 1; pos <= MAX_N; pos++) begin
      if (pos <= width + p && (pos & (pos - 1)) != 0) begin
        if (data[di[5:0]]) par[MAX_P-1:0] ^= pos[MAX_P-1:0];
        ovr ^= data[di[5:0]];
        di++;
      end
    end
    ovr ^= ^par[MAX_P-1:0];
    par[p[2:0]] = ovr;
    return par;
  endfunction

  function automatic hc_dec_t hamming_decode(input logic [MAX_W-1:0] data,
                                             input logic [PW-1:0]    parity,
                                             input int               width);
    hc_dec_t       r;
    logic [PW-1:0] rec;
    logic          ovr;
    int            p;
    int            di;
    p   = hamming_p(width);
    rec = hamming_encode(data, width);
    r.syndrome = '0;
    for (int j = 0; j < MAX_P; j++) begin
      if (j < p) r.syndrome[j] = rec[j] ^ parity[j];
    end
    // Overall parity across every stored bit; a clean codeword XORs to zero.
    ovr          = (^data) ^ (^parity);
    r.single_err = ovr;
    r.double_err = !ovr && (r.syndrome != '0);
    r.data       = data;
    di           = 0;
    // Only data positions need flipping; a syndrome pointing at a check bit
    // (or zero, the overall bit) leaves the data as stored.
    for (int pos = 1; pos <= MAX_N; pos++) begin
      if (pos <= width + p && (pos & (pos - 1)) != 0) begin
        if (ovr && int'(r.syndrome) == pos) r.data[di[5:0]] = ~data[di[5:0]];
        di++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder/corrector, reusable by any protected register.
//   raw_data   : stored data word (WIDTH)
//   raw_parity : stored Hamming bits [P-1:0] and overall parity [P]
//   fixed_data : data with any single-bit data error flipped back
//   syndrome   : recomputed ^ stored Hamming bits
//   single_err : overall parity mismatch (one bit upset, correctable)
//   double_err : nonzero syndrome with matching overall parity (uncorrectable)
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int P     = hamming_p(WIDTH)
) (
  input  logic [WIDTH-1:0] raw_data,
  input  logic [P:0]       raw_parity,
  output logic [WIDTH-1:0] fixed_data,
  output logic [P-1:0]     syndrome,
  output logic             single_err,
  output logic             double_err
);

  hc_dec_t res;
  // The decode struct is sized for the widest word; the padding bits are
  // folded here so that only the slices this width needs reach the ports.
  logic    unused_res;

  always_comb begin
    res        = hamming_decode(MAX_W'(raw_data), PW'(raw_parity), WIDTH);
    fixed_data = res.data[WIDTH-1:0];
    syndrome   = res.syndrome[P-1:0];
    single_err = res.single_err;
    double_err = res.double_err;
    unused_res = ^res;
  end

endmodule

// File: rtl/hamming_secded_counter.sv
// Up/down counter held in SEC-DED protected storage (count_reg + parity_stored).
// The stored word is decoded every cycle; single-bit upsets are corrected on
// the fly, scrubbed back at the next edge and counted; double-bit upsets freeze
// the counter until load or reset.
//   clk           : rising-edge clock
//   reset         : asynchronous active-high, clears all state
//   enable        : count one step per cycle
//   up_down       : 1 = increment, 0 = decrement
//   load          : synchronous load of load_value, highest priority after reset
//   load_value    : value written on load
//   counter       : decoded word (raw count_reg while frozen), combinational
//   corrected     : one-cycle pulse after an edge that scrubbed a single error
//   uncorrectable : sticky double-error flag
//   err_count     : saturating count of corrected errors
module hamming_secded_counter
  import hamming_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int ERR_CNT_W = 8,
  localparam int P         = hamming_p(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 up_down,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  output logic [WIDTH-1:0]     counter,
  output logic                 corrected,
  output logic                 uncorrectable,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] count_reg;
  logic [P:0]       parity_stored;
  hc_state_e        state;

  logic [WIDTH-1:0] fixed_data;
  logic [P-1:0]     dec_syndrome;
  logic             single_err;
  logic             double_err;

  logic [WIDTH-1:0] step_data;
  logic [WIDTH-1:0] write_data;
  logic [PW-1:0]    enc_full;
  logic [P:0]       write_parity;
  logic             unused_dec;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  hamming_secded_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .raw_data   (count_reg),
    .raw_parity (parity_stored),
    .fixed_data (fixed_data),
    .syndrome   (dec_syndrome),
    .single_err (single_err),
    .double_err (double_err)
  );

  // Every write re-encodes from the corrected word, so stepping and loading
  // both scrub a pending single error for free.
  always_comb begin
    step_data = up_down ? fixed_data + WIDTH'(1) : fixed_data - WIDTH'(1);
    if (load) begin
      write_data = load_value;
    end else if (enable) begin
      write_data = step_data;
    end else begin
      write_data = fixed_data;
    end
    enc_full     = hamming_encode(MAX_W'(write_data), WIDTH);
    write_parity = enc_full[P:0];
    unused_dec   = ^{dec_syndrome, enc_full};
  end

  // A frozen counter shows the raw word: the decoder cannot be trusted there.
  assign counter = (state == FAULT) ? count_reg : fixed_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= '0;
      parity_stored <= '0;
      state         <= NORMAL;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      err_count     <= '0;
    end else begin
      corrected <= 1'b0;
      if (load) begin
        count_reg     <= write_data;
        parity_stored <= write_parity;
        uncorrectable <= 1'b0;
        state         <= NORMAL;
      end else if (state == FAULT) begin
        // storage frozen until load or reset
      end else if (double_err) begin
        state         <= FAULT;
        uncorrectable <= 1'b1;
      end else if (enable || single_err) begin
        count_reg     <= write_data;
        parity_stored <= write_parity;
        if (single_err) begin
          corrected <= 1'b1;
          err_count <= sat_inc(err_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_counter.sv
// Bench for hamming_secded_counter: a 16-bit/8-bit-error-counter instance and an
// 8-bit/2-bit-error-counter instance run side by side against a behavioural
// model that tracks the counter value, pending upsets and the error bookkeeping.
module tb_hamming_secded_counter;

  logic        clk = 1'b0;
  logic        reset;

  logic        en16, ud16, ld16;
  logic [15:0] lv16, cnt16;
  logic        corr16, unc16;
  logic [7:0]  err16;

  logic        en8, ud8, ld8;
  logic [7:0]  lv8, cnt8;
  logic        corr8, unc8;
  logic [1:0]  err8;

  hamming_secded_counter #(.WIDTH(16), .ERR_CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .enable(en16), .up_down(ud16), .load(ld16),
    .load_value(lv16), .counter(cnt16), .corrected(corr16),
    .uncorrectable(unc16), .err_count(err16)
  );

  hamming_secded_counter #(.WIDTH(8), .ERR_CNT_W(2)) dut8 (
    .clk(clk), .reset(reset), .enable(en8), .up_down(ud8), .load(ld8),
    .load_value(lv8), .counter(cnt8), .corrected(corr8),
    .uncorrectable(unc8), .err_count(err8)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mw[2]   = '{16, 8};
  int          mp[2]   = '{5, 4};
  int          emax[2] = '{255, 3};
  logic [63:0] m_cnt[2];
  logic [63:0] m_dmask[2];
  int          m_err[2];
  bit          m_unc[2], m_corr[2], m_sgl[2], m_dbl[2];

  function automatic logic [63:0] wmask(input int i);
    return (64'd1 << mw[i]) - 64'd1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0; m_dmask[i] = '0; m_err[i] = 0;
      m_unc[i] = 0; m_corr[i] = 0; m_sgl[i] = 0; m_dbl[i] = 0;
    end
  endfunction

  // A pending double upset (m_dbl) doubles as the frozen state: storage is
  // never rewritten in that state, so the upset stays until a load.
  function automatic void model_edge(input int i, input bit e, input bit ud,
                                     input bit ld, input logic [63:0] lv);
    m_corr[i] = 0;
    if (ld) begin
      m_cnt[i] = lv & wmask(i);
      m_unc[i] = 0; m_sgl[i] = 0; m_dbl[i] = 0; m_dmask[i] = '0;
    end else if (m_dbl[i]) begin
      m_unc[i] = 1;
    end else if (e || m_sgl[i]) begin
      if (e) m_cnt[i] = (ud ? m_cnt[i] + 64'd1 : m_cnt[i] - 64'd1) & wmask(i);
      if (m_sgl[i]) begin
        m_corr[i] = 1;
        if (m_err[i] < emax[i]) m_err[i]++;
      end
      m_sgl[i] = 0; m_dmask[i] = '0;
    end
  endfunction

  function automatic logic [63:0] exp_counter(input int i);
    return m_dbl[i] ? (m_cnt[i] ^ m_dmask[i]) : m_cnt[i];
  endfunction

  task automatic check_outputs();
    chk("cnt16", 64'(cnt16), exp_counter(0));
    chk("corr16", 64'(corr16), 64'(m_corr[0]));
    chk("unc16", 64'(unc16), 64'(m_unc[0]));
    chk("err16", 64'(err16), 64'(m_err[0]));
    chk("cnt8", 64'(cnt8), exp_counter(1));
    chk("corr8", 64'(corr8), 64'(m_corr[1]));
    chk("unc8", 64'(unc8), 64'(m_unc[1]));
    chk("err8", 64'(err8), 64'(m_err[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, en16, ud16, ld16, 64'(lv16));
    model_edge(1, en8, ud8, ld8, 64'(lv8));
    #1;
    check_outputs();
  endtask

  // ---------------- fault injection ----------------
  logic [15:0] t16;
  logic [5:0]  p16;
  logic [7:0]  t8;
  logic [4:0]  p8;

  task automatic inject(input int i, input logic [63:0] dm, input logic [7:0] pm);
    if (i == 0) begin
      t16 = dut16.count_reg ^ dm[15:0];
      p16 = dut16.parity_stored ^ pm[5:0];
      force dut16.count_reg = t16;
      force dut16.parity_stored = p16;
      #1;
      release dut16.count_reg;
      release dut16.parity_stored;
    end else begin
      t8 = dut8.count_reg ^ dm[7:0];
      p8 = dut8.parity_stored ^ pm[4:0];
      force dut8.count_reg = t8;
      force dut8.parity_stored = p8;
      #1;
      release dut8.count_reg;
      release dut8.parity_stored;
    end
    if ($countones(dm) + $countones(pm) == 1) m_sgl[i] = 1;
    else m_dbl[i] = 1;
    m_dmask[i] = dm;
  endtask

  task automatic inject_random(input int i, input int nbits);
    logic [63:0] dm;
    logic [7:0]  pm;
    int          tot, k1, k2;
    dm  = '0;
    pm  = '0;
    tot = mw[i] + mp[i] + 1;
    k1  = $urandom_range(tot - 1, 0);
    if (k1 < mw[i]) dm[k1] = 1'b1; else pm[k1 - mw[i]] = 1'b1;
    if (nbits == 2) begin
      k2 = k1;
      while (k2 == k1) k2 = $urandom_range(tot - 1, 0);
      if (k2 < mw[i]) dm[k2] = 1'b1; else pm[k2 - mw[i]] = 1'b1;
    end
    inject(i, dm, pm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    en16 = 0; ud16 = 0; ld16 = 0; lv16 = '0;
    en8  = 0; ud8  = 0; ld8  = 0; lv8  = '0;
    model_reset();
    #12;
    check_outputs();
    chk("creg16_rst", 64'(dut16.count_reg), 64'h0);
    chk("par16_rst", 64'(dut16.parity_stored), 64'h0);
    reset = 1'b0;

    // count up to 30
    en16 = 1; ud16 = 1;
    repeat (30) step();
    chk("cnt16_30", 64'(cnt16), 64'h1E);

    // single data-bit upset: corrected in place, scrubbed at the next edge
    en16 = 0;
    inject(0, 64'h8, 8'h0);
    chk("cnt16_midfix", 64'(cnt16), 64'h1E);
    step();
    chk("corr16_pulse", 64'(corr16), 64'h1);
    chk("err16_one", 64'(err16), 64'h1);
    chk("creg16_scrub", 64'(dut16.count_reg), 64'h1E);
    step();

    // single check-bit upset
    inject(0, 64'h0, 8'h1);
    chk("cnt16_parfix", 64'(cnt16), 64'h1E);
    step();
    chk("err16_two", 64'(err16), 64'h2);
    step();

    // double upset freezes the counter
    en16 = 1; ud16 = 1;
    inject(0, 64'h88, 8'h0);
    step();
    chk("unc16_set", 64'(unc16), 64'h1);
    repeat (5) begin
      step();
      chk("cnt16_frozen", 64'(cnt16), 64'(16'h1E ^ 16'h88));
    end
    en16 = 0; ld16 = 1; lv16 = 16'h8000;
    step();
    ld16 = 0;
    chk("unc16_clr", 64'(unc16), 64'h0);
    chk("cnt16_load", 64'(cnt16), 64'h8000);

    // wrap both directions
    ld16 = 1; lv16 = 16'hFFFF;
    step();
    ld16 = 0; en16 = 1; ud16 = 1;
    step();
    chk("cnt16_wrapup", 64'(cnt16), 64'h0);
    ud16 = 0;
    step();
    chk("cnt16_wrapdn", 64'(cnt16), 64'hFFFF);
    en16 = 0;

    // asynchronous reset between edges at 0x0012
    ld16 = 1; lv16 = 16'h0;
    step();
    ld16 = 0; en16 = 1; ud16 = 1;
    repeat (18) step();
    chk("cnt16_12", 64'(cnt16), 64'h12);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    en16 = 0;
    #2;
    reset = 1'b0;

    // error counter saturation on the narrow instance
    repeat (5) begin
      inject_random(1, 1);
      step();
    end
    chk("err8_sat", 64'(err8), 64'h3);

    // randomized traffic with upsets on both instances
    repeat (600) begin
      ld16 = ($urandom_range(15, 0) == 0);
      lv16 = 16'($urandom);
      en16 = 1'($urandom_range(1, 0));
      ud16 = 1'($urandom_range(1, 0));
      ld8  = ($urandom_range(15, 0) == 0);
      lv8  = 8'($urandom);
      en8  = 1'($urandom_range(1, 0));
      ud8  = 1'($urandom_range(1, 0));
      for (int i = 0; i < 2; i++) begin
        if (!m_sgl[i] && !m_dbl[i] && $urandom_range(7, 0) == 0)
          inject_random(i, ($urandom_range(19, 0) == 0) ? 2 : 1);
      end
      chk("cnt16_mid", 64'(cnt16), exp_counter(0));
      chk("cnt8_mid", 64'(cnt8), exp_counter(1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
